// File: rtl/icache_2way_if.sv
`default_nettype none
// icache_2way_if: fetch port, refill port, statistics and debug bundle of the 2-way icache.
interface icache_2way_if;
  logic [31:0]  cpu_addr;
  logic         cpu_req;
  logic [31:0]  cpu_data;
  logic         cpu_ready;
  logic         cpu_stall;
  logic [31:0]  mem_addr;
  logic         mem_req;
  logic [31:0]  mem_data;
  logic         mem_ready;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [31:0]  stall_cycles;
  logic         debug_en;
  logic [127:0] debug_info;

  modport slave (
    input  cpu_addr, cpu_req, cpu_stall, mem_data, mem_ready, debug_en,
    output cpu_data, cpu_ready, mem_addr, mem_req, hit_count, miss_count, stall_cycles, debug_info
  );

  modport master (
    output cpu_addr, cpu_req, cpu_stall, mem_data, mem_ready, debug_en,
    input  cpu_data, cpu_ready, mem_addr, mem_req, hit_count, miss_count, stall_cycles, debug_info
  );
endinterface
`default_nettype wire

// File: rtl/icache_2way.sv
`default_nettype none
// icache_2way: 2-way set-associative read-only icache, combinational hit, word-serial 4-word refill.
// Optional statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_2way #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  icache_2way_if.slave bus
);
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;

  logic [SETS-1:0]       valid_q [2];
  logic [TAG_W-1:0]      tag_q   [2][SETS];
  logic [31:0]           data_q  [2][SETS][4];
  logic [SETS-1:0]       lru_q;

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TAG_W-1:0]      line_tag_q;
  logic [INDEX_BITS-1:0] line_idx_q;
  logic                  victim_q;

  logic [1:0]            off;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            way_hit;
  logic                  lookup, hit, miss, hit_way, victim, fill, fill_last;
  logic                  unused_addr_bits;

  assign off = bus.cpu_addr[3:2];
  assign idx = bus.cpu_addr[INDEX_BITS+3:4];
  assign tag = bus.cpu_addr[31:INDEX_BITS+4];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign way_hit[0] = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign way_hit[1] = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign lookup     = rst_ni && bus.cpu_req && (state_q == S_IDLE);
  assign hit        = lookup && (|way_hit);
  assign miss       = lookup && !(|way_hit);
  assign hit_way    = ~way_hit[0];
  // Empty ways are filled before anything is evicted; way0 wins a tie.
  assign victim     = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign fill       = rst_ni && (state_q == S_REFILL) && bus.mem_ready;
  assign fill_last  = fill && (cnt_q == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d = S_REFILL;
          cnt_d   = 2'd0;
        end
      end
      S_REFILL: begin
        if (fill) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      line_tag_q <= '0;
      line_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (miss) begin
        line_tag_q <= tag;
        line_idx_q <= idx;
        victim_q   <= victim;
      end
      if (hit && !bus.cpu_stall) lru_q[idx] <= ~hit_way;
      // A line only becomes valid once all four words are in, so an aborted fill leaves it invalid.
      if (fill_last) begin
        valid_q[victim_q][line_idx_q] <= 1'b1;
        lru_q[line_idx_q]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill)      data_q[victim_q][line_idx_q][cnt_q] <= bus.mem_data;
    if (fill_last) tag_q[victim_q][line_idx_q]         <= line_tag_q;
  end

  assign bus.cpu_ready = hit;
  assign bus.cpu_data  = hit ? data_q[hit_way][idx][off] : '0;
  assign bus.mem_req   = rst_ni && (state_q == S_REFILL);
  assign bus.mem_addr  = {line_tag_q, line_idx_q, cnt_q, 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hit && !bus.cpu_stall) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (bus.cpu_req && !hit) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count    = hit_cnt_q;
  assign bus.miss_count   = miss_cnt_q;
  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.hit_count    = '0;
  assign bus.miss_count   = '0;
  assign bus.stall_cycles = '0;
`endif

  assign bus.debug_info = (rst_ni && bus.debug_en)
    ? {bus.cpu_addr, bus.mem_addr, bus.hit_count, state_q, cnt_q, victim_q, hit, 26'd0}
    : '0;
endmodule
`default_nettype wire

// File: tb/tb_icache_2way.sv
`default_nettype none
// tb_icache_2way: randomized scoreboard bench with a recency-list cache model and a word-serial ROM memory.
module tb_icache_2way;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready_gate = 1'b0;

  icache_2way_if bus();

  icache_2way #(.INDEX_BITS(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        exp_q[$];
  logic [31:0] mem_exp[$];
  int          gaps[$];
  int          waited = 0;
  int          gap_rem = 0;
  bit          gap_loaded = 1'b0;

  // Model: per set, up to two line tags ordered most-recently-used first.
  logic [23:0] m_tag [16][2];
  int          m_n   [16];
  int unsigned m_hit, m_miss, m_stall;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign bus.mem_ready = bus.mem_req & ready_gate;
  assign bus.mem_data  = bus.mem_ready ? rom(bus.mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned v);
    return STATS ? v : 32'd0;
  endfunction

  function automatic bit m_has(input logic [31:0] a);
    for (int k = 0; k < m_n[a[7:4]]; k++)
      if (m_tag[a[7:4]][k] == a[31:8]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_use(input logic [31:0] a);
    logic [3:0] s;
    s = a[7:4];
    if (m_has(a)) begin
      if (m_tag[s][0] != a[31:8]) begin
        m_tag[s][1] = m_tag[s][0];
        m_tag[s][0] = a[31:8];
      end
    end else begin
      m_tag[s][1] = m_tag[s][0];
      m_tag[s][0] = a[31:8];
      if (m_n[s] < 2) m_n[s]++;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 16; s++) m_n[s] = 0;
    m_hit = 0; m_miss = 0; m_stall = 0;
  endtask

  // Memory side: chooses mem_ready for the coming edge and checks the requested word address.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      chk("mem_addr", bus.mem_addr, (mem_exp.size() != 0) ? mem_exp[0] : 32'hFFFF_FFFF);
      if (!gap_loaded) begin
        gap_rem    = (gaps.size() != 0) ? gaps.pop_front() : 0;
        gap_loaded = 1'b1;
      end
      if (gap_rem > 0) begin
        ready_gate = 1'b0;
        gap_rem--;
      end else begin
        ready_gate = 1'b1;
        gap_loaded = 1'b0;
        if (mem_exp.size() != 0) void'(mem_exp.pop_front());
      end
    end else begin
      ready_gate = 1'b0;
      gap_loaded = 1'b0;
    end
  end

  // CPU side: every cpu_ready cycle consumes one expected word and checks its latency.
  always @(negedge clk) begin
    exp_t e;
    if (bus.cpu_req) begin
      if (bus.cpu_ready) begin
        if (exp_q.size() == 0) begin
          chk("cpu_ready_unexpected", bus.cpu_ready, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_data", bus.cpu_data, e.data);
          chk("hit_latency", waited, e.lat);
        end
        waited = 0;
      end else begin
        waited++;
      end
    end else begin
      chk("cpu_ready_without_req", bus.cpu_ready, 1'b0);
    end
  end

  task automatic chk_counters();
    chk("hit_count", bus.hit_count, exp_cnt(m_hit));
    chk("miss_count", bus.miss_count, exp_cnt(m_miss));
    chk("stall_cycles", bus.stall_cycles, exp_cnt(m_stall));
  endtask

  task automatic chk_in_reset();
    @(negedge clk);
    chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_cpu_data", bus.cpu_data, 32'd0);
    chk("rst_debug_info", bus.debug_info, 128'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.debug_en = 1'b1;
    chk_in_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waited = 0;
    m_clear();
    chk_counters();
  endtask

  // Called at posedge+1; returns at posedge+1 with cpu_req dropped.
  task automatic access(input logic [31:0] a, input logic [15:0] gp, input bit stall,
                        input int hold, input bit dbg);
    bit          h;
    int          lat;
    int unsigned hit_before;
    exp_t        e;
    h = m_has(a);
    lat = 0;
    hit_before = m_hit;
    if (!h) begin
      lat = 5;
      for (int k = 0; k < 4; k++) begin
        gaps.push_back(int'(gp[k*4 +: 4]));
        lat += int'(gp[k*4 +: 4]);
        mem_exp.push_back({a[31:4], 4'(k * 4)});
      end
      m_miss++;
    end
    m_stall += lat;
    if (!h || !stall) m_use(a);
    if (!stall) m_hit += hold;
    for (int i = 0; i < hold; i++) begin
      e.data = rom({a[31:2], 2'b00});
      e.lat  = (i == 0) ? lat : 0;
      exp_q.push_back(e);
    end
    bus.cpu_addr  = a;
    bus.cpu_req   = 1'b1;
    bus.cpu_stall = stall;
    if (dbg) begin
      @(negedge clk);
      if (bus.debug_en)
        chk("debug_fields",
            {bus.debug_info[127:96], bus.debug_info[63:32], bus.debug_info[26], bus.debug_info[25:0]},
            {a, exp_cnt(hit_before), h, 26'd0});
      else
        chk("debug_off", bus.debug_info, 128'd0);
    end
    repeat (lat + hold) @(posedge clk);
    #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_stall = 1'b0;
    chk_counters();
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] gp;
    bit          st;
    int          hold;
    bus.cpu_addr = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.debug_en = 1'b1;
    m_clear();
    @(posedge clk); #1;
    do_reset();

    // Cold miss with the completing hit stalled, then hits on the rest of the line.
    access(32'h0000_0000, 16'h0000, 1'b1, 1, 1'b1);
    access(32'h0000_0004, 16'h0000, 1'b0, 1, 1'b1);
    access(32'h0000_0008, 16'h0000, 1'b0, 1, 1'b0);
    bus.debug_en = 1'b0;
    access(32'h0000_000C, 16'h0000, 1'b0, 1, 1'b1);
    bus.debug_en = 1'b1;

    // LRU eviction within set 0, then stalled hits that must not refresh recency.
    do_reset();
    access(32'h0000_0000, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0100, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0000, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0200, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0000, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0100, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0004, 16'h0000, 1'b1, 5, 1'b1);
    access(32'h0000_0208, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_010C, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0000, 16'h0000, 1'b0, 1, 1'b0);

    // Slow memory: three idle cycles before the second word.
    access(32'h0000_0340, 16'h0030, 1'b0, 1, 1'b0);
    for (int k = 0; k < 4; k++) access(32'h0000_0340 + 32'(k * 4), 16'h0000, 1'b0, 1, 1'b0);

    // Reset after two refill words, held with cpu_req=1, then the same line refills in full.
    mem_exp.push_back(32'h0000_0500);
    mem_exp.push_back(32'h0000_0504);
    bus.cpu_addr = 32'h0000_0500;
    bus.cpu_req  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk_in_reset();
    chk("abort_words_taken", mem_exp.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waited = 0;
    m_clear();
    access(32'h0000_0500, 16'h0000, 1'b0, 1, 1'b0);
    access(32'h0000_0504, 16'h0000, 1'b0, 1, 1'b0);

    // Random traffic over a few sets and tags.
    for (int i = 0; i < 150; i++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 2'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      for (int k = 0; k < 4; k++)
        gp[k*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      st   = m_has(a) && ($urandom_range(0, 4) == 0);
      hold = st ? $urandom_range(1, 4) : 1;
      bus.debug_en = 1'($urandom_range(0, 1));
      access(a, gp, st, hold, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mem_exp_drained", mem_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache_2way.md
# icache_2way

Two-way set-associative, read-only instruction cache between the pipeline's fetch port and the instruction memory. Lookup is combinational, so a hit returns data in the same cycle. A miss refills one 4-word line word-by-word over a simple req/ready memory port. It also keeps hit, miss and stall statistics, and exposes a debug snapshot.

## Interface
- INDEX_BITS, 4: set index width (16 sets); line is 4 words (16 bytes), fixed.
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored.
- cpu_req  in  1  fetch request.
- cpu_data  out  32  instruction word; valid when cpu_ready=1, otherwise 0.
- cpu_ready  out  1  hit this cycle (combinational).
- cpu_stall  in  1  CPU back-pressure; while 1, hits are not counted and LRU is not updated.
- mem_addr  out  32  refill word address.
- mem_req  out  1  refill word request.
- mem_data  in  32  refill word; sampled when mem_req && mem_ready.
- mem_ready  in  1  memory word valid; may be combinational on mem_req.
- hit_count, miss_count, stall_cycles  out  32 each  statistics counters; wrap modulo 2^32.
- debug_en  in  1  enables debug_info.
- debug_info  out  128  debug snapshot. With debug_en=1: [127:96]=cpu_addr, [95:64]=mem_addr, [63:32]=hit_count, [31:30]=state, [29:28]=refill word counter, [27]=victim way, [26]=hit, rest 0. With debug_en=0: all 0.

## Operation
- Address split: offset [3:2], index [INDEX_BITS+3:4], tag [31:INDEX_BITS+4].
- Per set: two ways, each holding a valid bit, a tag and 4 data words. One LRU bit per set points at the least-recently-used way.
- Hit condition: cpu_req=1, state=IDLE, and a valid way's tag matches. On a hit, cpu_ready=1 and cpu_data = word[offset] of the matching way.
- States:
  - IDLE → REFILL when cpu_req=1 and there is no hit. On this transition: latch line address, choose victim, miss_count += 1, clear word counter.
  - REFILL: mem_req=1, mem_addr = {latched tag, index, word counter, 2'b00}. Each cycle with mem_ready=1 writes mem_data into the victim's word[counter] and increments the counter.
  - REFILL → IDLE after word 3 is accepted. On this transition: set victim valid, write tag, set LRU to the other way.
- Victim choice: the first invalid way (way0 preferred); if both ways are valid, the LRU way.
- Hit with cpu_stall=0: hit_count += 1 and LRU points to the non-hit way.
- stall_cycles += 1 in every cycle with cpu_req=1 and cpu_ready=0, including the miss-detect cycle and all REFILL cycles.
- cpu_ready=0 throughout REFILL. A cpu_addr change during REFILL does not abort the fill; the new address is looked up in IDLE afterwards.
- cpu_req=0 in IDLE: no miss is started and no counters change.
- Cache contents are never written by the CPU; there is no invalidate port.

## Timing
- Hit latency: 0 cycles (combinational, same cycle as the request).
- Miss penalty with memory always ready: miss detected in cycle 0; refill words in cycles 1–4; hit in cycle 5. stall_cycles grows by 5 per miss.
- mem_ready held low stretches REFILL with no upper bound; mem_req stays high.
- Reset (reset=0 at a clock edge): all valid bits, LRU bits, counters and the word counter go to 0; state=IDLE. While reset=0: cpu_ready=0, mem_req=0, cpu_data=0, debug_info=0.
- Reset asserted mid-refill aborts the fill; the partially filled way stays invalid.
- Leaving reset with cpu_req=1 starts a fill of the line at cpu_addr on the first active cycle.

## Configuration
- ICACHE_STATS_EN defined: hit_count, miss_count and stall_cycles are implemented as specified.
- ICACHE_STATS_EN not defined: the three counters are tied to 0, debug_info[63:32]=0, and all other behaviour is unchanged.

## Test plan
- Cold miss: after reset release, cpu_addr=0, mem_ready=mem_req → mem_addr steps 0,4,8,12 on cycles 1–4; cpu_ready=1 on cycle 5; miss_count=1, stall_cycles=5.
- Line hit: following the cold miss, addresses 4, 8, 12 → cpu_ready=1 same cycle with the ROM words; hit_count=3, miss_count unchanged.
- LRU eviction: fill 0x000, fill 0x100, hit 0x000, then access 0x200 → the 0x100 line is evicted; 0x000 still hits; 0x100 misses again; miss_count=4.
- Slow memory: mem_ready low for 3 cycles mid-refill → mem_addr held, no word written; fill completes correctly afterwards.
- cpu_stall=1 with a hitting address for 5 cycles → cpu_ready=1, hit_count and LRU unchanged.
- Reset mid-refill after 2 words, then re-access the same line → full 4-word refill, miss_count=1 (counters were cleared by the reset).
